glyph_rom_bank: RTL and testbench

Parameterised multi-glyph bitmap store for the digit-recognition display path, holding NUM_GLYPHS glyphs of ROWS×COLS pixels. It serves a registered random-access lookup port for the matcher and a row-streaming engine with a valid/ready handshake for the VGA overlay. Optionally, it accepts run-time glyph writes so that recognition templates can be retrained without a rebuild.

---
 rtl/glyph_pkg.sv | 53 +++++
 rtl/glyph_rom_bank_if.sv | 38 +++
 rtl/glyph_mem.sv | 68 ++++++
 rtl/glyph_rom_bank.sv | 111 +++++++++++
 tb/tb_glyph_rom_bank.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph bitmap store: default sizes, digit index
// constants, stream FSM states and the built-in 16x16 digit table.
// Bit 15 of each table word is the leftmost pixel.
package glyph_pkg;

  localparam int DEF_GLYPHS = 10;
  localparam int DEF_ROWS   = 16;
  localparam int DEF_COLS   = 16;

  localparam int GLYPH_ZERO  = 0;
  localparam int GLYPH_ONE   = 1;
  localparam int GLYPH_TWO   = 2;
  localparam int GLYPH_THREE = 3;
  localparam int GLYPH_FOUR  = 4;
  localparam int GLYPH_FIVE  = 5;
  localparam int GLYPH_SIX   = 6;
  localparam int GLYPH_SEVEN = 7;
  localparam int GLYPH_EIGHT = 8;
  localparam int GLYPH_NINE  = 9;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} st_state_e;

  localparam logic [15:0] GLYPH_TABLE [DEF_GLYPHS][DEF_ROWS] = '{
    '{16'h0FF0, 16'h1FF8, 16'h381C, 16'h700E, 16'h700E, 16'h700E, 16'h700E, 16'h700E,
      16'h700E, 16'h700E, 16'h700E, 16'h700E, 16'h700E, 16'h381C, 16'h1FF8, 16'h0FF0},
    '{16'h01C0, 16'h03C0, 16'h07C0, 16'h0DC0, 16'h01C0, 16'h01C0, 16'h01C0, 16'h01C0,
      16'h01C0, 16'h01C0, 16'h01C0, 16'h01C0, 16'h01C0, 16'h01C0, 16'h0FF8, 16'h0FF8},
    '{16'h0FF0, 16'h1FF8, 16'h381C, 16'h000E, 16'h000E, 16'h001C, 16'h0038, 16'h0070,
      16'h00E0, 16'h01C0, 16'h0380, 16'h0700, 16'h0E00, 16'h1C00, 16'h3FFE, 16'h3FFE},
    '{16'h1FF0, 16'h3FF8, 16'h001C, 16'h000E, 16'h000E, 16'h001C, 16'h07F8, 16'h07F8,
      16'h001C, 16'h000E, 16'h000E, 16'h000E, 16'h001C, 16'h3FF8, 16'h1FF0, 16'h0000},
    '{16'h0038, 16'h0078, 16'h00F8, 16'h01B8, 16'h0338, 16'h0638, 16'h0C38, 16'h1838,
      16'h3038, 16'h7FFE, 16'h7FFE, 16'h0038, 16'h0038, 16'h0038, 16'h0038, 16'h0038},
    '{16'h7FFE, 16'h7FFE, 16'h7000, 16'h7000, 16'h7000, 16'h7FF0, 16'h7FF8, 16'h001C,
      16'h000E, 16'h000E, 16'h000E, 16'h000E, 16'h700E, 16'h381C, 16'h1FF8, 16'h0FF0},
    '{16'h1FF8, 16'h3FFC, 16'h7000, 16'hE000, 16'hE000, 16'hEFF0, 16'hFFF8, 16'hF01C,
      16'hE00E, 16'hE00F, 16'hE00E, 16'hE00E, 16'h700E, 16'h781C, 16'h3FF8, 16'h0FE0},
    '{16'h7FFE, 16'h7FFE, 16'h000E, 16'h001C, 16'h0038, 16'h0070, 16'h00E0, 16'h01C0,
      16'h0380, 16'h0380, 16'h0700, 16'h0700, 16'h0700, 16'h0700, 16'h0700, 16'h0700},
    '{16'h0FF0, 16'h1FF8, 16'h381C, 16'h381C, 16'h381C, 16'h1C38, 16'h0FF0, 16'h0FF0,
      16'h1C38, 16'h381C, 16'h700E, 16'h700E, 16'h700E, 16'h381C, 16'h1FF8, 16'h0FF0},
    '{16'h0FF0, 16'h1FF8, 16'h381C, 16'h700E, 16'h700E, 16'h700E, 16'h381E, 16'h1FFE,
      16'h0FEE, 16'h000E, 16'h000E, 16'h000E, 16'h001C, 16'h0038, 16'h1FF0, 16'h0FE0}
  };

  // Power-up content of one word; glyphs/rows beyond the built-in table are blank.
  function automatic logic [15:0] default_word(input int g, input int r);
    if (g >= 0 && g < DEF_GLYPHS && r >= 0 && r < DEF_ROWS)
      return GLYPH_TABLE[g[3:0]][r[3:0]];
    return 16'h0000;
  endfunction

endpackage

// File: rtl/glyph_rom_bank_if.sv
// Lookup, stream and write signal bundle for glyph_rom_bank.
// master = client side (matcher/overlay/trainer), slave = the glyph store.
// Stream uses valid/ready; lookup and write are single-cycle strobes.
interface glyph_rom_bank_if #(
  parameter int GW   = 4,
  parameter int RW   = 4,
  parameter int COLS = 16
);
  logic            lk_en;
  logic [GW-1:0]   lk_glyph;
  logic [RW-1:0]   lk_row;
  logic [COLS-1:0] lk_data;
  logic            lk_valid;
  logic            st_start;
  logic [GW-1:0]   st_glyph;
  logic            st_busy;
  logic            st_valid;
  logic            st_ready;
  logic [RW-1:0]   st_row;
  logic [COLS-1:0] st_data;
  logic            st_last;
  logic            wr_en;
  logic [GW-1:0]   wr_glyph;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_data;

  modport master (
    output lk_en, lk_glyph, lk_row, st_start, st_glyph, st_ready,
           wr_en, wr_glyph, wr_row, wr_data,
    input  lk_data, lk_valid, st_busy, st_valid, st_row, st_data, st_last
  );

  modport slave (
    input  lk_en, lk_glyph, lk_row, st_start, st_glyph, st_ready,
           wr_en, wr_glyph, wr_row, wr_data,
    output lk_data, lk_valid, st_busy, st_valid, st_row, st_data, st_last
  );
endinterface

// File: rtl/glyph_mem.sv
// Glyph word storage: two combinational range-checked read ports, one write port.
// Reads return zero for out-of-range indices; writes land on the next edge (old data read same cycle).
// GLYPH_WRITE_EN selects writable RAM; otherwise constant ROM and wr_* are ignored.
module glyph_mem
  import glyph_pkg::*;
#(
  parameter int NUM_GLYPHS = DEF_GLYPHS,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int GW         = $clog2(NUM_GLYPHS),
  parameter int RW         = $clog2(ROWS)
) (
  input  logic            clk_i,
  input  logic [GW-1:0]   rd_a_glyph_i,
  input  logic [RW-1:0]   rd_a_row_i,
  output logic [COLS-1:0] rd_a_data_o,
  input  logic [GW-1:0]   rd_b_glyph_i,
  input  logic [RW-1:0]   rd_b_row_i,
  output logic [COLS-1:0] rd_b_data_o,
  input  logic            wr_en_i,
  input  logic [GW-1:0]   wr_glyph_i,
  input  logic [RW-1:0]   wr_row_i,
  input  logic [COLS-1:0] wr_data_i
);

  localparam int DEPTH = NUM_GLYPHS * ROWS;
  localparam int AW    = $clog2(DEPTH);

  // Extra bit keeps the compare meaningful when ROWS/NUM_GLYPHS is a power of two.
  function automatic logic in_range(input logic [GW-1:0] g, input logic [RW-1:0] r);
    return ({1'b0, g} < (GW+1)'(NUM_GLYPHS)) && ({1'b0, r} < (RW+1)'(ROWS));
  endfunction

  function automatic logic [AW-1:0] word_addr(input logic [GW-1:0] g, input logic [RW-1:0] r);
    return AW'(int'(g) * ROWS + int'(r));
  endfunction

  logic [COLS-1:0] words [DEPTH];

`ifdef GLYPH_WRITE_EN
  logic          wr_hit;
  logic [AW-1:0] wr_addr;
  assign wr_hit  = wr_en_i && in_range(wr_glyph_i, wr_row_i);
  assign wr_addr = word_addr(wr_glyph_i, wr_row_i);
`else
  logic unused_wr;
  assign unused_wr = ^{clk_i, wr_en_i, wr_glyph_i, wr_row_i, wr_data_i};
`endif

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    localparam int G = w / ROWS;
    localparam int R = w % ROWS;
`ifdef GLYPH_WRITE_EN
    logic [COLS-1:0] word_q = COLS'(default_word(G, R));
    // Retrain this word when a write addresses it; no reset, content survives rst_n.
    always_ff @(posedge clk_i) begin
      if (wr_hit && wr_addr == AW'(w)) word_q <= wr_data_i;
    end
    assign words[w] = word_q;
`else
    assign words[w] = COLS'(default_word(G, R));
`endif
  end

  assign rd_a_data_o = in_range(rd_a_glyph_i, rd_a_row_i) ? words[word_addr(rd_a_glyph_i, rd_a_row_i)] : '0;
  assign rd_b_data_o = in_range(rd_b_glyph_i, rd_b_row_i) ? words[word_addr(rd_b_glyph_i, rd_b_row_i)] : '0;

endmodule

// File: rtl/glyph_rom_bank.sv
// Glyph bitmap store with a registered lookup port and a row-streaming engine.
// Lookup: 1 cycle; stream: first row 2 cycles after st_start, then 2 cycles/row.
// Stream row held stable until st_ready; GLYPH_WRITE_EN enables run-time writes.
module glyph_rom_bank
  import glyph_pkg::*;
#(
  parameter int NUM_GLYPHS = DEF_GLYPHS,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int GW         = $clog2(NUM_GLYPHS),
  parameter int RW         = $clog2(ROWS)
) (
  input logic             clk,
  input logic             rst_n,
  glyph_rom_bank_if.slave io
);

  logic [COLS-1:0] rd_a_data;
  logic [COLS-1:0] rd_b_data;

  logic [COLS-1:0] lk_data_q;
  logic            lk_valid_q;

  st_state_e       state_q;
  logic [GW-1:0]   glyph_q;
  logic [RW-1:0]   row_q;
  logic            busy_q;
  logic            valid_q;
  logic            last_q;
  logic [COLS-1:0] st_data_q;

  glyph_mem #(
    .NUM_GLYPHS(NUM_GLYPHS), .ROWS(ROWS), .COLS(COLS), .GW(GW), .RW(RW)
  ) u_mem (
    .clk_i        (clk),
    .rd_a_glyph_i (io.lk_glyph),
    .rd_a_row_i   (io.lk_row),
    .rd_a_data_o  (rd_a_data),
    .rd_b_glyph_i (glyph_q),
    .rd_b_row_i   (row_q),
    .rd_b_data_o  (rd_b_data),
    .wr_en_i      (io.wr_en),
    .wr_glyph_i   (io.wr_glyph),
    .wr_row_i     (io.wr_row),
    .wr_data_i    (io.wr_data)
  );

  // Lookup register: valid pulses for one cycle, data holds until the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_data_q  <= '0;
      lk_valid_q <= 1'b0;
    end else begin
      lk_valid_q <= io.lk_en;
      if (io.lk_en) lk_data_q <= rd_a_data;
    end
  end

  // Stream engine: LOAD captures a row, SEND holds it until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      glyph_q   <= '0;
      row_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      st_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.st_start) begin
            glyph_q <= io.st_glyph;
            row_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          st_data_q <= rd_b_data;
          last_q    <= (row_q == RW'(ROWS - 1));
          valid_q   <= 1'b1;
          state_q   <= SEND;
        end
        SEND: begin
          if (io.st_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              row_q   <= row_q + RW'(1);
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.lk_data  = lk_data_q;
  assign io.lk_valid = lk_valid_q;
  assign io.st_busy  = busy_q;
  assign io.st_valid = valid_q;
  assign io.st_row   = row_q;
  assign io.st_data  = st_data_q;
  assign io.st_last  = last_q;

endmodule

// File: tb/tb_glyph_rom_bank.sv
// Directed bench for glyph_rom_bank: lookup, streaming, stalls, out-of-range,
// write-through (when GLYPH_WRITE_EN is defined) and mid-stream reset.
module tb_glyph_rom_bank;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   bc;

  logic [15:0] g6 [16] = '{
    16'h1FF8, 16'h3FFC, 16'h7000, 16'hE000, 16'hE000, 16'hEFF0, 16'hFFF8, 16'hF01C,
    16'hE00E, 16'hE00F, 16'hE00E, 16'hE00E, 16'h700E, 16'h781C, 16'h3FF8, 16'h0FE0
  };

  glyph_rom_bank_if #(.GW(4), .RW(4), .COLS(16)) io_if ();

  glyph_rom_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lk_data"},  32'(io_if.lk_data),  32'h0);
    check({tag, "_lk_valid"}, 32'(io_if.lk_valid), 32'h0);
    check({tag, "_st_data"},  32'(io_if.st_data),  32'h0);
    check({tag, "_st_valid"}, 32'(io_if.st_valid), 32'h0);
    check({tag, "_st_busy"},  32'(io_if.st_busy),  32'h0);
    check({tag, "_st_last"},  32'(io_if.st_last),  32'h0);
    check({tag, "_st_row"},   32'(io_if.st_row),   32'h0);
  endtask

  task automatic lookup(input logic [3:0] g, input logic [3:0] r, input logic [15:0] exp, input string tag);
    io_if.lk_en = 1'b1; io_if.lk_glyph = g; io_if.lk_row = r;
    tick();
    io_if.lk_en = 1'b0;
    check({tag, "_data"},  32'(io_if.lk_data),  32'(exp));
    check({tag, "_valid"}, 32'(io_if.lk_valid), 32'h1);
  endtask

  // Streams one glyph; zero selects all-zero expected rows, stall_row holds st_ready low for 5 cycles.
  task automatic run_stream(input logic [3:0] g, input bit zero, input int stall_row, output int busy_cycles);
    int got, cyc, first_v;
    logic [15:0] exp;
    got = 0; cyc = 0; first_v = -1;
    io_if.st_glyph = g; io_if.st_start = 1'b1; io_if.st_ready = 1'b1;
    tick(); cyc = 1;
    io_if.st_start = 1'b0;
    check("busy_t1",  32'(io_if.st_busy),  32'h1);
    check("valid_t1", 32'(io_if.st_valid), 32'h0);
    while (io_if.st_busy && cyc < 200) begin
      if (io_if.st_valid) begin
        if (first_v < 0) first_v = cyc;
        exp = zero ? 16'h0 : g6[got[3:0]];
        if (got == stall_row) begin
          io_if.st_ready = 1'b0;
          for (int k = 0; k < 5; k++) begin
            io_if.st_start = 1'b1; io_if.st_glyph = 4'hF;
            tick(); cyc++;
            check("stall_data",  32'(io_if.st_data),  32'(exp));
            check("stall_row",   32'(io_if.st_row),   32'(got));
            check("stall_valid", 32'(io_if.st_valid), 32'h1);
          end
          io_if.st_start = 1'b0; io_if.st_glyph = g; io_if.st_ready = 1'b1;
        end
        check("row_idx",  32'(io_if.st_row),  32'(got));
        check("row_data", 32'(io_if.st_data), 32'(exp));
        check("row_last", 32'(io_if.st_last), (got == 15) ? 32'h1 : 32'h0);
        got++;
      end
      tick(); cyc++;
    end
    check("stream_timeout", (cyc < 200) ? 32'h1 : 32'h0, 32'h1);
    check("first_valid", 32'(first_v), 32'd2);
    check("row_count",   32'(got),     32'd16);
    busy_cycles = cyc - 1;
  endtask

  initial begin
    rst_n = 1'b0;
    io_if.lk_en = 1'b0; io_if.lk_glyph = '0; io_if.lk_row = '0;
    io_if.st_start = 1'b0; io_if.st_glyph = '0; io_if.st_ready = 1'b0;
    io_if.wr_en = 1'b0; io_if.wr_glyph = '0; io_if.wr_row = '0; io_if.wr_data = '0;
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    lookup(4'd6, 4'd0, 16'h1FF8, "lk_g6r0");
    lookup(4'd6, 4'd3, 16'hE000, "lk_g6r3");
    lookup(4'd6, 4'd9, 16'hE00F, "lk_g6r9");
    tick();
    check("lk_pulse", 32'(io_if.lk_valid), 32'h0);
    check("lk_hold",  32'(io_if.lk_data),  32'hE00F);

    run_stream(4'd6, 1'b0, -1, bc);
    check("busy_len", 32'(bc), 32'd32);
    run_stream(4'd6, 1'b0, 4, bc);
    check("busy_len_stall", 32'(bc), 32'd37);
    run_stream(4'd15, 1'b1, -1, bc);
    check("busy_len_oor", 32'(bc), 32'd32);

    lookup(4'd12, 4'd3, 16'h0000, "lk_oor");

    io_if.wr_en = 1'b1; io_if.wr_glyph = 4'd2; io_if.wr_row = 4'd5; io_if.wr_data = 16'hA5A5;
    lookup(4'd2, 4'd5, 16'h001C, "wr_rbw");
    io_if.wr_en = 1'b0;
`ifdef GLYPH_WRITE_EN
    lookup(4'd2, 4'd5, 16'hA5A5, "wr_after");
`else
    lookup(4'd2, 4'd5, 16'h001C, "wr_after");
`endif

    io_if.st_glyph = 4'd6; io_if.st_start = 1'b1; io_if.st_ready = 1'b1;
    tick();
    io_if.st_start = 1'b0;
    for (int n = 0; n < 100 && !(io_if.st_valid && io_if.st_row == 4'd7); n++) tick();
    check("rst_reach_row7", 32'(io_if.st_row),   32'd7);
    check("rst_reach_vld",  32'(io_if.st_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(io_if.st_valid), 32'h0);
    check("post_rst_busy",  32'(io_if.st_busy),  32'h0);
    run_stream(4'd6, 1'b0, -1, bc);
    check("busy_len_post_rst", 32'(bc), 32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
